cpu_run_sequencer: RTL and testbench
====================================

Name: cpu_run_sequencer

Overview:
Hardware harness controller that loads a machine-code program into the 8-bit CPU's instruction store and sequences CPU reset. It then runs the CPU for a bounded number of cycles and reports pass, fail or timeout against an expected ALU result. It replaces fixed-delay reset and finish timing with a parametrised, handshaked sequencer, and sits between a host/loader port and the CPU's clk, reset and instruction_write_data interface.

Parameters:
DATA_W, 8, width of instruction words and ALU result
PROG_DEPTH, 16, max program words; address width AW = $clog2(PROG_DEPTH)
RESET_CYCLES, 7, cycles cpu_reset is held high after load completes (>=1)
TIMEOUT_CYCLES, 64, max run cycles before timeout (>=1); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins load phase when IDLE or DONE
prog_valid  in  1  host word valid
prog_data  in  DATA_W  host machine-code word
prog_last  in  1  marks final program word (qualified by prog_valid)
prog_ready  out  1  sequencer accepts word this cycle
expected  in  DATA_W  expected ALU result, sampled at start
alu_result  in  DATA_W  CPU ALU output
instr_wr_en  out  1  CPU instruction-store write strobe
instr_wr_addr  out  AW  write address
instr_wr_data  out  DATA_W  write data
cpu_reset  out  1  reset to CPU, active-high
busy  out  1  high in LOAD/HOLD/RUN
done  out  1  high in DONE
pass  out  1  valid when done: 1 = match, 0 = timeout or overflow
err_overflow  out  1  sticky until next start: program exceeded PROG_DEPTH

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DONE. Encoding is in the package.
- Reset values: state=IDLE, cpu_reset=1, prog_ready=0, instr_wr_en=0, addr=0, data=0, busy=0, done=0, pass=0, err_overflow=0, all counters 0.
- IDLE/DONE + start -> LOAD. In the same edge: latch expected, clear addr/pass/err_overflow, drive cpu_reset=1. start is ignored in LOAD/HOLD/RUN.
- LOAD behaviour:
  - prog_ready=1.
  - Handshake = prog_valid&&prog_ready. On the next cycle: instr_wr_en=1 for exactly one cycle, with the registered addr/data (1-cycle write latency). addr then increments.
  - A handshake with prog_last -> HOLD.
  - A handshake while addr==PROG_DEPTH-1 without prog_last: the word is written, err_overflow=1, and the state goes to DONE with pass=0.
  - prog_valid low stalls indefinitely, with no timeout.
- HOLD: prog_ready=0 and cpu_reset=1 for exactly RESET_CYCLES cycles, counted from HOLD entry. Then -> RUN. cpu_reset falls on the RUN-entry edge.
- RUN:
  - cpu_reset=0 and the run counter increments each cycle from 0.
  - Registered compare: if alu_result==expected_latched -> DONE, pass=1.
  - Else if counter==TIMEOUT_CYCLES-1 -> DONE, pass=0.
  - If a match and the timeout occur in the same cycle, the match wins.
- DONE: done=1 and cpu_reset=1 (the CPU is parked); pass holds. start -> LOAD.
- The final instr_wr_en pulse of LOAD lands during the first HOLD cycle. This is legal because cpu_reset is held.
- busy = state in {LOAD,HOLD,RUN}. done and busy are never both high.
- Async reset mid-operation: immediate return to reset values. A partially loaded program is abandoned, with no further writes.
- Counters saturate, never wrap. addr does not wrap past PROG_DEPTH-1.

Optional Feature:
Macro CPU_RUN_SEQ_CYCLE_COUNT_EN.
- Defined: adds output run_cycles [$clog2(TIMEOUT_CYCLES+1)-1:0]. It holds the RUN cycle count at DONE entry (match cycle index +1, or TIMEOUT_CYCLES on timeout), is cleared at start, and resets to 0.
- Undefined: the port and register are absent. All other behaviour is identical.

Decomposition:
- Package cpu_run_seq_pkg: state enum (IDLE, LOAD, HOLD, RUN, DONE) and the clog2-width helper constants.
- One natural sub-module, seq_down_counter: a loadable saturating counter with a terminal flag, instantiated for both HOLD and RUN timing. The FSM stays in the top.

Test Plan:
1. Load 3 words 0x11,0x22,0x33 with prog_last on the 3rd -> writes at addr 0,1,2 with matching data and one-cycle pulses; cpu_reset high for 7 cycles after the last handshake, then low.
2. expected=0x5A; alu_result driven to 0x5A on RUN cycle 4 -> done=1, pass=1, cpu_reset=1 next edge; run_cycles=5 with the macro defined.
3. expected=0xFF; alu_result never matches, TIMEOUT_CYCLES=64 -> DONE after 64 RUN cycles, pass=0.
4. PROG_DEPTH=16, 17 words with no prog_last -> 16 writes (addr 0..15), err_overflow=1, done=1, pass=0, no HOLD/RUN.
5. Assert reset mid-LOAD after 2 words -> outputs return to reset values immediately; a new start reloads from addr 0.
6. Toggle prog_valid 1/0 every cycle in LOAD, and pulse start during RUN -> only valid words are written, start is ignored, and the final result is unchanged versus an unstalled run.

Source files
------------

// File: rtl/cpu_run_seq_pkg.sv
// Shared types and width helpers for the CPU run sequencer.
package cpu_run_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

  // Width able to hold the value n itself (counters that count up to n).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Address width for a store of the given depth; never zero.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that sticks at zero; term flags the zero count.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      count <= '0;
    else if (load)                  count <= load_val;
    else if (en && (count != '0))   count <= count - W'(1);
  end

  assign term = (count == '0);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Loads a program into the CPU instruction store, holds CPU reset, runs it
// with a timeout and reports pass/fail. CPU_RUN_SEQ_CYCLE_COUNT_EN adds run_cycles.
module cpu_run_sequencer
  import cpu_run_seq_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int PROG_DEPTH     = 16,
  parameter int RESET_CYCLES   = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           prog_valid,
  input  logic [DATA_W-1:0]              prog_data,
  input  logic                           prog_last,
  output logic                           prog_ready,
  input  logic [DATA_W-1:0]              expected,
  input  logic [DATA_W-1:0]              alu_result,
  output logic                           instr_wr_en,
  output logic [addr_w(PROG_DEPTH)-1:0]  instr_wr_addr,
  output logic [DATA_W-1:0]              instr_wr_data,
  output logic                           cpu_reset,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           err_overflow
`ifdef CPU_RUN_SEQ_CYCLE_COUNT_EN
  ,
  output logic [cnt_w(TIMEOUT_CYCLES)-1:0] run_cycles
`endif
);

  localparam int AW  = addr_w(PROG_DEPTH);
  localparam int HCW = cnt_w(RESET_CYCLES);
  localparam int RCW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_DEPTH - 1);

  seq_state_t state, state_nxt;

  logic [DATA_W-1:0] exp_q;
  logic [AW-1:0]     addr;
  logic start_ok, hs, at_last_addr, match;
  logic hold_load, hold_term, run_load, run_term;

  assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
  assign hs           = prog_valid && prog_ready;
  assign at_last_addr = (addr == LAST_ADDR);
  assign match        = (alu_result == exp_q);
  assign hold_load    = (state == S_LOAD) && hs && prog_last;
  assign run_load     = (state == S_HOLD) && hold_term;

  // HOLD length: loaded with RESET_CYCLES-1 so the zero cycle is the last one.
  seq_down_counter #(.W(HCW)) u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (HCW'(RESET_CYCLES - 1)),
    .en       (state == S_HOLD),
    .term     (hold_term)
  );

  // RUN budget: term fires on run cycle TIMEOUT_CYCLES-1.
  seq_down_counter #(.W(RCW)) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (run_load),
    .load_val (RCW'(TIMEOUT_CYCLES - 1)),
    .en       (state == S_RUN),
    .term     (run_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (hs) begin
          if (prog_last)         state_nxt = S_HOLD;
          else if (at_last_addr) state_nxt = S_DONE;
        end
      end
      S_HOLD: if (hold_term) state_nxt = S_RUN;
      S_RUN:  if (match || run_term) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    prog_ready = (state == S_LOAD);
    busy       = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);
    done       = (state == S_DONE);
    cpu_reset  = (state != S_RUN);
  end

  // Write port trails the handshake by one cycle; the final pulse may land in HOLD or DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q         <= '0;
      addr          <= '0;
      instr_wr_en   <= 1'b0;
      instr_wr_addr <= '0;
      instr_wr_data <= '0;
      pass          <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      instr_wr_en <= 1'b0;
      if (start_ok) begin
        exp_q         <= expected;
        addr          <= '0;
        instr_wr_addr <= '0;
        pass          <= 1'b0;
        err_overflow  <= 1'b0;
      end
      if ((state == S_LOAD) && hs) begin
        instr_wr_en   <= 1'b1;
        instr_wr_addr <= addr;
        instr_wr_data <= prog_data;
        if (!at_last_addr)             addr         <= addr + AW'(1);
        if (at_last_addr && !prog_last) err_overflow <= 1'b1;
      end
      if ((state == S_RUN) && match) pass <= 1'b1;
    end
  end

`ifdef CPU_RUN_SEQ_CYCLE_COUNT_EN
  // Counts RUN cycles; the value left at DONE entry is the reported figure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  run_cycles <= '0;
    else if (start_ok)                                          run_cycles <= '0;
    else if ((state == S_RUN) && (run_cycles != RCW'(TIMEOUT_CYCLES))) run_cycles <= run_cycles + RCW'(1);
  end
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Randomized self-checking bench for cpu_run_sequencer against a behavioural model.
module tb_cpu_run_sequencer;

  localparam int DW = 8;
  localparam int PD = 16;
  localparam int RC = 7;
  localparam int TO = 64;
  localparam int AW = 4;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, prog_valid = 1'b0, prog_last = 1'b0;
  logic [DW-1:0] prog_data = '0, expected = '0, alu_result = '0;
  logic prog_ready, instr_wr_en, cpu_reset, busy, done, pass, err_overflow;
  logic [AW-1:0] instr_wr_addr;
  logic [DW-1:0] instr_wr_data;
`ifdef CPU_RUN_SEQ_CYCLE_COUNT_EN
  logic [CW-1:0] run_cycles;
`endif

  cpu_run_sequencer #(.DATA_W(DW), .PROG_DEPTH(PD), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .expected(expected), .alu_result(alu_result),
    .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr), .instr_wr_data(instr_wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass), .err_overflow(err_overflow)
`ifdef CPU_RUN_SEQ_CYCLE_COUNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] words[$];

  // Observation only: writes seen, HOLD cycles, RUN cycles, busy/done overlap.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int hold_cyc = 0, run_cyc = 0, overlap = 0;
  always @(negedge clk) begin
    if (instr_wr_en) begin
      wa_q.push_back(instr_wr_addr);
      wd_q.push_back(instr_wr_data);
    end
    if (busy && cpu_reset && !prog_ready) hold_cyc++;
    if (busy && !cpu_reset) run_cyc++;
    if (busy && done) overlap++;
  end

  task automatic pulse_start(input logic [DW-1:0] e);
    @(negedge clk);
    start = 1'b1;
    expected = e;
    @(negedge clk);
    start = 1'b0;
    expected = ~e;
  endtask

  task automatic load_prog(input int n, input bit use_last, input bit stall);
    int i;
    bit v;
    i = 0;
    for (int cyc = 0; cyc < 200 && i < n; cyc++) begin
      if (!prog_ready) break;
      v = stall ? (cyc % 2 == 0) : 1'b1;
      prog_valid = v;
      prog_data  = words[i];
      prog_last  = use_last && (i == n - 1);
      if (v) i++;
      @(negedge clk);
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic run_phase(input logic [DW-1:0] e, input int match_idx, input bit poke);
    int k;
    k = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) break;
      alu_result = e ^ 8'($urandom_range(1, 255));
      start = 1'b0;
      if (busy && !cpu_reset) begin
        if (k == match_idx) alu_result = e;
        if (poke && k == 2) start = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_program_run(input string name, input int n, input bit use_last, input bit stall,
                                  input logic [DW-1:0] e, input int match_idx, input bit poke);
    int base_w, base_h, base_r, got_w, exp_w, exp_rc, bad;
    bit ovf, exp_pass;
    ovf      = (n > PD) && !use_last;
    exp_w    = ovf ? PD : n;
    exp_pass = !ovf && match_idx >= 0 && match_idx < TO;
    exp_rc   = ovf ? 0 : (exp_pass ? match_idx + 1 : TO);
    base_w = wa_q.size(); base_h = hold_cyc; base_r = run_cyc;
    pulse_start(e);
    checks++;
    if (pass !== 1'b0 || err_overflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s start_clear: pass=%0b err=%0b busy=%0b done=%0b, want 0 0 1 0", name, pass, err_overflow, busy, done);
    else passed++;
    load_prog(n, use_last, stall);
    if (ovf) repeat (2) @(negedge clk);
    else run_phase(e, match_idx, poke);
    got_w = wa_q.size() - base_w;
    checks++;
    if (got_w !== exp_w) $display("FAIL %s write_count: got %0d want %0d", name, got_w, exp_w);
    else passed++;
    bad = 0;
    for (int i = 0; i < exp_w && i < got_w; i++)
      if (wa_q[base_w+i] !== AW'(i) || wd_q[base_w+i] !== words[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL %s write_addr_data: %0d wrong writes, want 0", name, bad);
    else passed++;
    checks++;
    if (hold_cyc - base_h !== (ovf ? 0 : RC)) $display("FAIL %s hold_cycles: got %0d want %0d", name, hold_cyc - base_h, ovf ? 0 : RC);
    else passed++;
    checks++;
    if (run_cyc - base_r !== exp_rc) $display("FAIL %s run_cycles_seen: got %0d want %0d", name, run_cyc - base_r, exp_rc);
    else passed++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1)
      $display("FAIL %s done_state: done=%0b busy=%0b cpu_reset=%0b, want 1 0 1", name, done, busy, cpu_reset);
    else passed++;
    checks++;
    if (pass !== exp_pass) $display("FAIL %s pass: got %0b want %0b", name, pass, exp_pass);
    else passed++;
    checks++;
    if (err_overflow !== ovf) $display("FAIL %s err_overflow: got %0b want %0b", name, err_overflow, ovf);
    else passed++;
`ifdef CPU_RUN_SEQ_CYCLE_COUNT_EN
    checks++;
    if (run_cycles !== CW'(exp_rc)) $display("FAIL %s run_cycles: got %0d want %0d", name, run_cycles, exp_rc);
    else passed++;
`endif
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_reset !== 1'b1 || prog_ready !== 1'b0 || instr_wr_en !== 1'b0 || instr_wr_addr !== '0 ||
        instr_wr_data !== '0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL reset_values: rst=%0b rdy=%0b we=%0b a=%0h d=%0h busy=%0b done=%0b pass=%0b err=%0b",
               cpu_reset, prog_ready, instr_wr_en, instr_wr_addr, instr_wr_data, busy, done, pass, err_overflow);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1)
      $display("FAIL idle_after_reset: busy=%0b done=%0b cpu_reset=%0b, want 0 0 1", busy, done, cpu_reset);
    else passed++;
  endtask

  task automatic test_load_and_pass;
    words.delete();
    words.push_back(8'h11); words.push_back(8'h22); words.push_back(8'h33);
    test_program_run("load_pass", 3, 1'b1, 1'b0, 8'h5A, 4, 1'b0);
  endtask

  task automatic test_timeout;
    fill_words(2);
    test_program_run("timeout", 2, 1'b1, 1'b0, 8'hFF, -1, 1'b0);
    fill_words(1);
    test_program_run("match_at_timeout", 1, 1'b1, 1'b0, 8'h3C, TO - 1, 1'b0);
  endtask

  task automatic test_overflow;
    fill_words(17);
    test_program_run("overflow", 17, 1'b0, 1'b0, 8'h42, 0, 1'b0);
    fill_words(16);
    test_program_run("full_depth", 16, 1'b1, 1'b0, 8'h42, 0, 1'b0);
  endtask

  task automatic test_reset_mid_load;
    int base_w;
    pulse_start(8'h3C);
    base_w = wa_q.size();
    prog_valid = 1'b1; prog_last = 1'b0; prog_data = 8'hA1;
    @(negedge clk);
    prog_data = 8'hA2;
    @(negedge clk);
    prog_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (instr_wr_en !== 1'b0 || cpu_reset !== 1'b1 || prog_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || instr_wr_addr !== '0 || instr_wr_data !== '0)
      $display("FAIL mid_load_reset: we=%0b rst=%0b rdy=%0b busy=%0b done=%0b a=%0h d=%0h", instr_wr_en,
               cpu_reset, prog_ready, busy, done, instr_wr_addr, instr_wr_data);
    else passed++;
    checks++;
    if (wa_q.size() - base_w !== 2 || wa_q[base_w+1] !== 4'd1 || wd_q[base_w+1] !== 8'hA2)
      $display("FAIL mid_load_writes: got %0d writes want 2 (addr1=A2)", wa_q.size() - base_w);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base_w = wa_q.size();
    repeat (3) @(negedge clk);
    checks++;
    if (wa_q.size() !== base_w || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abandoned_load: extra writes=%0d busy=%0b done=%0b, want 0 0 0", wa_q.size() - base_w, busy, done);
    else passed++;
    fill_words(3);
    test_program_run("reload", 3, 1'b1, 1'b0, 8'h77, 2, 1'b0);
  endtask

  task automatic test_stall_and_start;
    fill_words(5);
    test_program_run("unstalled", 5, 1'b1, 1'b0, 8'hC3, 10, 1'b0);
    test_program_run("stalled_poke", 5, 1'b1, 1'b1, 8'hC3, 10, 1'b1);
  endtask

  task automatic test_back_to_back;
    int n, m;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, PD);
      m = $urandom_range(0, TO + 6);
      fill_words(n);
      test_program_run($sformatf("random%0d", it), n, 1'b1, ($urandom_range(0, 1) == 1),
                       8'($urandom_range(0, 255)), m, ($urandom_range(0, 1) == 1));
    end
    checks++;
    if (overlap !== 0) $display("FAIL busy_done_overlap: got %0d cycles want 0", overlap);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_load_and_pass;
    test_timeout;
    test_overflow;
    test_reset_mid_load;
    test_stall_and_start;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
